// File: rtl/gen_reduce_seq.sv
// Time-multiplexed CHUNK-ary AND-reduction: one shared CHUNK-input AND unit walks
// the tree level by level, reducing a WIDTH-bit word in place, one group per cycle.
module gen_reduce_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned LVL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             busy,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned NGRP  = WIDTH / CHUNK;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned LW_W  = $clog2(WIDTH + 1);
    localparam int unsigned SH    = $clog2(CHUNK);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [LW_W-1:0]  lw_q, lw_d;
    logic             out_data_q, out_data_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             grp_and;
    logic             last_grp;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            level_q     <= '0;
            grp_q       <= '0;
            lw_q        <= '0;
            out_data_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            level_q     <= level_d;
            grp_q       <= grp_d;
            lw_q        <= lw_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, shared AND unit and in-place write-back
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        level_d    = level_q;
        grp_d      = grp_q;
        lw_d       = lw_q;
        out_data_d = out_data_q;
        grp_and    = 1'b1;
        last_grp   = (grp_q == GRP_W'((lw_q >> SH) - LW_W'(1)));

        for (int unsigned j = 0; j < NGRP; j++) begin
            if (GRP_W'(j) == grp_q) grp_and = &work_q[j*CHUNK +: CHUNK];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    level_d = '0;
                    grp_d   = '0;
                    lw_d    = LW_W'(WIDTH);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                // Group g lands in bit g; it only reads bits >= g*CHUNK, so nothing unread is lost
                for (int unsigned j = 0; j < NGRP; j++) begin
                    if (GRP_W'(j) == grp_q) work_d[j] = grp_and;
                end
                grp_d = grp_q + GRP_W'(1);
                if (last_grp) begin
                    level_d = level_q + LVL_W'(1);
                    lw_d    = lw_q >> SH;
                    grp_d   = '0;
                    if (lw_q == LW_W'(CHUNK)) begin
                        out_data_d = grp_and;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == REDUCE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign level_o   = level_q;

endmodule

// File: tb/tb_gen_reduce_seq.sv
// Self-checking bench for gen_reduce_seq: 16/4, 64/4 and 4/4 instances on one clock.
module tb_gen_reduce_seq;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [63:0]      d_all;
    logic [2:0]       in_valid;
    logic [2:0]       out_ready;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_data;
    logic [2:0]       busy;
    logic [2:0][3:0]  lvl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gen_reduce_seq #(.WIDTH(16), .CHUNK(4), .LVL_W(4)) u_16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(d_all[15:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]), .level_o(lvl[0]));

    gen_reduce_seq #(.WIDTH(64), .CHUNK(4), .LVL_W(4)) u_64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(d_all), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]), .level_o(lvl[1]));

    gen_reduce_seq #(.WIDTH(4), .CHUNK(4), .LVL_W(4)) u_4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(d_all[3:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]), .level_o(lvl[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a W-wide word through a C-ary tree costs one cycle per node
    function automatic int tree_groups(input int w, input int c);
        int s = 0;
        for (int lw = w; lw > 1; lw = lw / c) s += lw / c;
        return s;
    endfunction

    function automatic int tree_levels(input int w, input int c);
        int k = 0;
        for (int lw = w; lw > 1; lw = lw / c) k++;
        return k;
    endfunction

    // One word through instance idx: accept, measure latency, optional backpressure, pop
    task automatic send(input int idx, input logic [63:0] data, input int hold,
                        input logic exp_out, input int exp_lat, input int exp_lvl);
        int  lat;
        bit  seen;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready[idx]), 64'd1);
        d_all          = data;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = (hold == 0);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        d_all         = {$urandom, $urandom};
        lat  = 0;
        seen = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            if (out_valid[idx]) begin
                seen = 1'b1;
                break;
            end
            if (!busy[idx] || in_ready[idx]) chk("busy_reduce", {in_ready[idx], busy[idx]}, 64'b01);
            @(posedge clk);
            lat++;
        end
        chk("result_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("out_data", 64'(out_data[idx]), 64'(exp_out));
        chk("level_done", 64'(lvl[idx]), 64'(exp_lvl));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_state", {out_valid[idx], out_data[idx], in_ready[idx], busy[idx]},
                {1'b1, exp_out, 2'b00});
        end
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        chk("pop_idle", {out_valid[idx], in_ready[idx]}, 64'b01);
    endtask

    typedef struct {
        logic [15:0] data;
        int          hold;
        logic        exp_out;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] w;
        logic        pend;
        int          ng16, ng64, ng4;

        vecs[0] = '{16'hFFFF, 0,  1'b1};
        vecs[1] = '{16'h7FFF, 0,  1'b0};
        vecs[2] = '{16'hFFFE, 0,  1'b0};
        vecs[3] = '{16'h0000, 0,  1'b0};
        vecs[4] = '{16'hFFFF, 10, 1'b1};
        vecs[5] = '{16'hF0FF, 10, 1'b0};
        vecs[6] = '{16'hFFBF, 2,  1'b0};
        vecs[7] = '{16'hFFFF, 3,  1'b1};
        vecs[8] = '{16'h8000, 1,  1'b0};
        vecs[9] = '{16'hFFF7, 0,  1'b0};

        ng16 = tree_groups(16, 4);
        ng64 = tree_groups(64, 4);
        ng4  = tree_groups(4, 4);

        rst_n     = 1'b0;
        d_all     = '0;
        in_valid  = '0;
        out_ready = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'b111);
        chk("rst_out_valid", 64'(out_valid), 64'b000);
        chk("rst_out_data", 64'(out_data), 64'b000);
        chk("rst_busy", 64'(busy), 64'b000);
        chk("rst_level", 64'(lvl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven words on the 16/4 instance
        foreach (vecs[i])
            send(0, 64'(vecs[i].data), vecs[i].hold, vecs[i].exp_out, ng16, tree_levels(16, 4));

        // Reset abandons a word in flight
        @(negedge clk);
        d_all       = 64'hFFFF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_busy", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {in_ready[0], out_valid[0], busy[0], out_data[0], lvl[0]},
            {4'b1000, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_spurious", {out_valid[0], in_ready[0]}, 64'b01);
        end

        // Random words through the 64/4 instance
        for (int i = 0; i < 1000; i++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) w = '1;
            else if ($urandom_range(1, 0) == 1) w = ~(64'd1 << $urandom_range(63, 0));
            send(1, w, ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0,
                 &w, ng64, tree_levels(64, 4));
        end

        // WIDTH == CHUNK single word with backpressure
        send(2, 64'hF, 4, 1'b1, ng4, tree_levels(4, 4));

        // WIDTH == CHUNK back-to-back: accept, reduce, done repeats every ng4+2 cycles
        @(negedge clk);
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b1;
        pend         = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("b2b_in_ready", 64'(in_ready[2]), 64'((i % (ng4 + 2)) == 0));
            chk("b2b_out_valid", 64'(out_valid[2]), 64'((i % (ng4 + 2)) == ng4 + 1));
            if (out_valid[2]) chk("b2b_out_data", 64'(out_data[2]), 64'(pend));
            d_all = 64'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) d_all = 64'hF;
            if (in_ready[2]) pend = &d_all[3:0];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid[2] = 1'b0;
        repeat (4) @(negedge clk);
        out_ready[2] = 1'b0;
        chk("b2b_idle", {in_ready[2], out_valid[2]}, 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
